// File: rtl/shift_arb_ctrl_pkg.sv
// shift_arb_ctrl_pkg: FSM state encoding and requester indices shared by the shift/arbiter slice.
package shift_arb_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;
endpackage

// File: rtl/shift_arb_ctrl_shift_chain.sv
// shift_chain: parallel-load left shift register, MSB out, zero fill.
module shift_chain #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             msb
);
    logic [WIDTH-1:0] chain;
    always_ff @(posedge clock) begin
        if (!clear) chain <= '0;
        else if (load) chain <= din;
        else if (shift) chain <= {chain[WIDTH-2:0], 1'b0};
    end
    assign msb = chain[WIDTH-1];
endmodule

// File: rtl/shift_arb_ctrl.sv
// shift_arb_ctrl: round-robin arbiter of two requesters feeding one MSB-first serial stream.
module shift_arb_ctrl
    import shift_arb_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             clear,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    output logic [1:0]       ack,
    output logic             sout,
    output logic             sout_valid,
    input  logic             sout_ready,
    output logic             done,
    output logic             done_id,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    state_t state;
    logic [CW-1:0] cnt;
    logic owner, prio, grant, load, shift, msb;
    // prio names the requester that wins a tie; it becomes the loser of the last word
    assign grant = (req == 2'b11) ? prio : (req[REQ1] ? REQ1 : REQ0);
    assign load = (state == IDLE) && (req != 2'b00);
    assign shift = (state == SHIFT) && sout_ready;
    assign sout = sout_valid & msb;
    shift_chain #(.WIDTH(WIDTH)) u_chain (
        .clock(clock),
        .clear(clear),
        .load(load),
        .shift(shift),
        .din(grant ? data1 : data0),
        .msb(msb)
    );
    always_ff @(posedge clock) begin
        if (!clear) begin
            state <= IDLE;
            cnt <= '0;
            owner <= REQ0;
            prio <= REQ0;
            ack <= 2'b00;
            sout_valid <= 1'b0;
            done <= 1'b0;
            done_id <= 1'b0;
            busy <= 1'b0;
        end else begin
            ack <= 2'b00;
            done <= 1'b0;
            case (state)
                IDLE: if (load) begin
                    state <= SHIFT;
                    cnt <= '0;
                    owner <= grant;
                    ack <= grant ? 2'b10 : 2'b01;
                    sout_valid <= 1'b1;
                    busy <= 1'b1;
                end
                SHIFT: if (shift) begin
                    cnt <= (cnt == LAST) ? cnt : cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= DONE;
                        sout_valid <= 1'b0;
                        done <= 1'b1;
                        done_id <= owner;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    prio <= ~owner;
                    busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_shift_arb_ctrl.sv
// tb_shift_arb_ctrl: scoreboard bench for the two-requester serializer (WIDTH=8 and WIDTH=2).
module tb_shift_arb_ctrl;
    logic clock = 1'b0;
    logic clear = 1'b0;
    logic [1:0] req = 2'b00;
    logic [7:0] data0 = '0, data1 = '0;
    logic [1:0] ack;
    logic sout, sout_valid, done, done_id, busy;
    logic sout_ready = 1'b1;
    logic [1:0] req2 = 2'b00;
    logic [1:0] d2 = 2'b10;
    logic [1:0] ack2;
    logic sout2, sout_valid2, done2, done_id2, busy2;
    int total = 0, passed = 0;
    logic bitq[$];
    logic idq[$];

    always #5 clock = ~clock;

    shift_arb_ctrl #(.WIDTH(8)) dut (
        .clock(clock), .clear(clear), .req(req), .data0(data0), .data1(data1),
        .ack(ack), .sout(sout), .sout_valid(sout_valid), .sout_ready(sout_ready),
        .done(done), .done_id(done_id), .busy(busy)
    );

    shift_arb_ctrl #(.WIDTH(2)) dut2 (
        .clock(clock), .clear(clear), .req(req2), .data0(d2), .data1(2'b01),
        .ack(ack2), .sout(sout2), .sout_valid(sout_valid2), .sout_ready(1'b1),
        .done(done2), .done_id(done_id2), .busy(busy2)
    );

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic push_word(input logic [7:0] w, input logic id);
        for (int i = 7; i >= 0; i--) bitq.push_back(w[i]);
        idq.push_back(id);
    endtask

    // waits for a grant, then for done; latency counted in cycles from the sampling edge
    task automatic serve(input logic [1:0] exp_ack, input int exp_wait, input logic keep,
                         input logic [1:0] raise);
        int w, n, extra;
        w = 0;
        do begin
            @(negedge clock);
            w++;
        end while (ack == 2'b00 && w < 30);
        check("grant_wait", w, exp_wait);
        check("ack", ack, exp_ack);
        if (!keep) req = req & ~exp_ack;
        req = req | raise;
        n = 1;
        extra = 0;
        while (!done && n < 40) begin
            @(negedge clock);
            n++;
            if (ack != 2'b00) extra++;
        end
        check("latency", n, 9);
        check("ack_in_word", extra, 0);
    endtask

    always @(negedge clock) begin
        #1;
        if (clear && sout_valid && sout_ready) begin
            if (bitq.size() == 0) check("extra_bit", 1, 0);
            else check("sout", sout, bitq.pop_front());
        end
        if (done) begin
            if (idq.size() == 0) check("spurious_done", 1, 0);
            else check("done_id", done_id, idq.pop_front());
        end
        if ($countones(ack) > 1) check("ack_onehot", ack, 0);
    end

    initial begin
        int n;
        repeat (2) @(negedge clock);
        check("rst_ack", ack, 0);
        check("rst_sout", sout, 0);
        check("rst_valid", sout_valid, 0);
        check("rst_done", done, 0);
        check("rst_done_id", done_id, 0);
        check("rst_busy", busy, 0);
        clear = 1'b1;
        // single word
        data0 = 8'hA5;
        push_word(8'hA5, 1'b0);
        req = 2'b01;
        serve(2'b01, 1, 1'b0, 2'b00);
        @(negedge clock);
        check("done_pulse", done, 0);
        check("idle_busy", busy, 0);
        // contention from reset
        clear = 1'b0;
        @(negedge clock);
        clear = 1'b1;
        data0 = 8'h0F;
        data1 = 8'hF0;
        push_word(8'h0F, 1'b0);
        push_word(8'hF0, 1'b1);
        push_word(8'h0F, 1'b0);
        req = 2'b11;
        serve(2'b01, 1, 1'b1, 2'b00);
        serve(2'b10, 2, 1'b1, 2'b00);
        serve(2'b01, 2, 1'b0, 2'b00);
        req = 2'b00;
        repeat (2) @(negedge clock);
        // backpressure after the first bit
        data0 = 8'h81;
        push_word(8'h81, 1'b0);
        req = 2'b01;
        @(negedge clock);
        check("bp_ack", ack, 2'b01);
        req = 2'b00;
        n = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            n++;
            sout_ready = 1'b0;
            check("bp_sout", sout, 0);
            check("bp_valid", sout_valid, 1);
        end
        @(negedge clock);
        n++;
        sout_ready = 1'b1;
        while (!done && n < 40) begin
            @(negedge clock);
            n++;
        end
        check("bp_latency", n, 12);
        repeat (2) @(negedge clock);
        // reset after four transfers
        data0 = 8'hC3;
        push_word(8'hC3, 1'b0);
        req = 2'b01;
        @(negedge clock);
        check("rm_ack", ack, 2'b01);
        req = 2'b00;
        repeat (4) @(negedge clock);
        clear = 1'b0;
        @(negedge clock);
        check("rm_busy", busy, 0);
        check("rm_valid", sout_valid, 0);
        check("rm_done", done, 0);
        check("rm_left", bitq.size(), 4);
        bitq.delete();
        idq.delete();
        clear = 1'b1;
        data1 = 8'h3C;
        push_word(8'h3C, 1'b1);
        req = 2'b10;
        serve(2'b10, 1, 1'b0, 2'b00);
        repeat (2) @(negedge clock);
        // late request during shift
        data0 = 8'h5A;
        data1 = 8'h96;
        push_word(8'h5A, 1'b0);
        push_word(8'h96, 1'b1);
        req = 2'b01;
        serve(2'b01, 1, 1'b0, 2'b10);
        serve(2'b10, 2, 1'b0, 2'b00);
        repeat (2) @(negedge clock);
        check("queue_empty", bitq.size() + idq.size(), 0);
        // two-bit chain
        req2 = 2'b01;
        @(negedge clock);
        check("w2_ack", ack2, 2'b01);
        check("w2_bit1", sout2, 1);
        check("w2_valid", sout_valid2, 1);
        req2 = 2'b00;
        @(negedge clock);
        check("w2_bit0", sout2, 0);
        check("w2_valid0", sout_valid2, 1);
        @(negedge clock);
        check("w2_done", done2, 1);
        check("w2_done_id", done_id2, 0);
        check("w2_valid_done", sout_valid2, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
